// File: rtl/score_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3) with a start/done handshake,
// leading-zero blanking and saturation to all nines on overflow.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one shift-add-3 iteration per clock, IN_WIDTH iterations total
module score_to_bcd_seq #(
  parameter int IN_WIDTH   = 32,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     value,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    overflow
);

  // Decimal digits needed to hold 2^w-1, i.e. ceil(w*log10(2)).
  function automatic int calc_digits(input int w);
    logic [63:0] m;
    int          d;
    m = (64'd1 << w) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (m != 64'd0) begin
        m = m / 64'd10;
        d++;
      end
    end
    return d;
  endfunction

  localparam int ID = calc_digits(IN_WIDTH);
  // Accumulator is never narrower than the output, so slicing stays legal.
  localparam int AD = (ID > NUM_DIGITS) ? ID : NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [NUM_DIGITS-1:0]   BLANK_RST = ~NUM_DIGITS'(1);
  localparam logic [4*NUM_DIGITS-1:0] SAT       = {NUM_DIGITS{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_q, state_d;
  logic [4*AD-1:0]     acc, adj, acc_nx;
  logic [IN_WIDTH-1:0] sh, sh_nx;
  logic [4*AD+IN_WIDTH-1:0] cat;
  logic [CW-1:0]       cnt;
  logic                load, step, fin;
  logic                ovf_nx, zero_run;
  logic [4*NUM_DIGITS-1:0] bcd_nx;
  logic [NUM_DIGITS-1:0]   blank_nx;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(IN_WIDTH - 1)) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adj = acc;
    for (int d = 0; d < AD; d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    cat    = {adj, sh} << 1;
    acc_nx = cat[4*AD+IN_WIDTH-1:IN_WIDTH];
    sh_nx  = cat[IN_WIDTH-1:0];
  end

  // Result formatting from the final iteration's digits.
  always_comb begin
    ovf_nx = 1'b0;
    for (int i = NUM_DIGITS; i < AD; i++) begin
      if (acc_nx[4*i +: 4] != 4'd0) ovf_nx = 1'b1;
    end
    bcd_nx   = ovf_nx ? SAT : acc_nx[4*NUM_DIGITS-1:0];
    blank_nx = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (bcd_nx[4*i +: 4] == 4'd0);
      if (i > 0) blank_nx[i] = zero_run;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc      <= '0;
      sh       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= fin;
      if (load) begin
        sh   <= value;
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end
      if (step) begin
        acc <= acc_nx;
        sh  <= sh_nx;
        cnt <= cnt + CW'(1);
      end
      if (fin) begin
        busy     <= 1'b0;
        bcd      <= bcd_nx;
        blank    <= blank_nx;
        overflow <= ovf_nx;
      end
    end
  end

endmodule

// File: tb/tb_score_to_bcd_seq.sv
// Directed bench for score_to_bcd_seq: 32-bit/6-digit and 16-bit/5-digit builds.
module tb_score_to_bcd_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        busy, done, overflow;
  logic [23:0] bcd;
  logic [5:0]  blank;

  logic        start16 = 1'b0;
  logic [15:0] value16 = '0;
  logic        busy16, done16, overflow16;
  logic [19:0] bcd16;
  logic [4:0]  blank16;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  score_to_bcd_seq #(.IN_WIDTH(32), .NUM_DIGITS(6)) dut (
    .clock(clock), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank), .overflow(overflow)
  );

  score_to_bcd_seq #(.IN_WIDTH(16), .NUM_DIGITS(5)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .value(value16),
    .busy(busy16), .done(done16), .bcd(bcd16), .blank(blank16), .overflow(overflow16)
  );

  // Drives a one-cycle start; returns at the negedge after the accepting edge.
  task automatic accept(input logic [31:0] v);
    @(negedge clock);
    start = 1'b1;
    value = v;
    @(negedge clock);
    start = 1'b0;
    value = 32'hDEAD_BEEF;
  endtask

  // Counts edges until done is seen (bounded); lat == edges since the accept edge.
  task automatic wait_done(input int lat0, output int lat, output int busy_bad);
    lat = lat0;
    busy_bad = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bcd !== 24'h0) begin errors++; $display("FAIL reset_bcd got=%h exp=000000", bcd); end
    checks++; if (blank !== 6'b111110) begin errors++; $display("FAIL reset_blank got=%b exp=111110", blank); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    reset = 1'b0;
  endtask

  task automatic test_zero;
    int lat, bb;
    accept(32'd0);
    wait_done(0, lat, bb);
    checks++; if (lat !== 32) begin errors++; $display("FAIL zero_latency got=%0d exp=32", lat); end
    checks++; if (bcd !== 24'h000000) begin errors++; $display("FAIL zero_bcd got=%h exp=000000", bcd); end
    checks++; if (blank !== 6'b111110) begin errors++; $display("FAIL zero_blank got=%b exp=111110", blank); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_basic;
    int lat, bb;
    accept(32'd123456);
    wait_done(0, lat, bb);
    checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency got=%0d exp=32", lat); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy_low_cycles got=%0d exp=0", bb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    checks++; if (bcd !== 24'h123456) begin errors++; $display("FAIL basic_bcd got=%h exp=123456", bcd); end
    checks++; if (blank !== 6'b000000) begin errors++; $display("FAIL basic_blank got=%b exp=000000", blank); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (bcd !== 24'h123456) begin errors++; $display("FAIL basic_hold got=%h exp=123456", bcd); end
  endtask

  task automatic test_blanking;
    int lat, bb;
    accept(32'd907);
    wait_done(0, lat, bb);
    checks++; if (bcd !== 24'h000907) begin errors++; $display("FAIL b907_bcd got=%h exp=000907", bcd); end
    checks++; if (blank !== 6'b111000) begin errors++; $display("FAIL b907_blank got=%b exp=111000", blank); end
  endtask

  task automatic test_overflow;
    int lat, bb;
    accept(32'd999999);
    wait_done(0, lat, bb);
    checks++; if (bcd !== 24'h999999) begin errors++; $display("FAIL max_bcd got=%h exp=999999", bcd); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL max_ovf got=%b exp=0", overflow); end
    accept(32'd1000000);
    wait_done(0, lat, bb);
    checks++; if (bcd !== 24'h999999) begin errors++; $display("FAIL ovf_bcd got=%h exp=999999", bcd); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (blank !== 6'b000000) begin errors++; $display("FAIL ovf_blank got=%b exp=000000", blank); end
    accept(32'hFFFF_FFFF);
    wait_done(0, lat, bb);
    checks++; if (bcd !== 24'h999999) begin errors++; $display("FAIL ffff_bcd got=%h exp=999999", bcd); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ffff_ovf got=%b exp=1", overflow); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL ffff_latency got=%0d exp=32", lat); end
  endtask

  task automatic test_handshake;
    int lat, bb;
    accept(32'd42);
    repeat (9) @(negedge clock);
    checks++; if (bcd !== 24'h999999 || overflow !== 1'b1) begin
      errors++; $display("FAIL hold_while_busy got=%h/%b exp=999999/1", bcd, overflow); end
    start = 1'b1;
    value = 32'd77;
    @(negedge clock);
    start = 1'b0;
    wait_done(10, lat, bb);
    checks++; if (lat !== 32) begin errors++; $display("FAIL ignore_latency got=%0d exp=32", lat); end
    checks++; if (bcd !== 24'h000042) begin errors++; $display("FAIL ignore_bcd got=%h exp=000042", bcd); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ignore_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_back_to_back;
    int lat, bb;
    // Still in the done cycle left by test_handshake.
    start = 1'b1;
    value = 32'd77;
    @(negedge clock);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    checks++; if (bcd !== 24'h000042) begin errors++; $display("FAIL b2b_hold got=%h exp=000042", bcd); end
    wait_done(0, lat, bb);
    checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
    checks++; if (bcd !== 24'h000077) begin errors++; $display("FAIL b2b_bcd got=%h exp=000077", bcd); end
    checks++; if (blank !== 6'b111100) begin errors++; $display("FAIL b2b_blank got=%b exp=111100", blank); end
  endtask

  task automatic test_reset_abort;
    int lat, bb, pulses;
    accept(32'd555);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (bcd !== 24'h0) begin errors++; $display("FAIL abort_bcd got=%h exp=000000", bcd); end
    checks++; if (blank !== 6'b111110 || overflow !== 1'b0) begin
      errors++; $display("FAIL abort_blank_ovf got=%b/%b exp=111110/0", blank, overflow); end
    pulses = 0;
    repeat (40) begin
      if (done === 1'b1) pulses++;
      @(negedge clock);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    accept(32'd8);
    wait_done(0, lat, bb);
    checks++; if (bcd !== 24'h000008) begin errors++; $display("FAIL after_abort_bcd got=%h exp=000008", bcd); end
    checks++; if (blank !== 6'b111110) begin errors++; $display("FAIL after_abort_blank got=%b exp=111110", blank); end
  endtask

  task automatic test_w16;
    int lat;
    @(negedge clock);
    start16 = 1'b1;
    value16 = 16'd65535;
    @(negedge clock);
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL w16_latency got=%0d exp=16", lat); end
    checks++; if (bcd16 !== 20'h65535) begin errors++; $display("FAIL w16_bcd got=%h exp=65535", bcd16); end
    checks++; if (blank16 !== 5'b00000 || overflow16 !== 1'b0) begin
      errors++; $display("FAIL w16_blank_ovf got=%b/%b exp=00000/0", blank16, overflow16); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_blanking();
    test_overflow();
    test_handshake();
    test_back_to_back();
    test_reset_abort();
    test_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_to_bcd_seq.md
Name: score_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter for the on-screen score and other numeric displays.
- Parametrised successor to the combinational divide/modulo digit splitter. It uses an iterative shift-add-3 (double-dabble) datapath with a start/done handshake, so there are no wide dividers.
- Generalised in input width and digit count. Adds leading-zero blanking and overflow saturation.
- Sits between the game-logic score register and the seven-segment digit drivers.

Parameters:
- IN_WIDTH, 32, bit width of the unsigned binary input (legal 4..32).
- NUM_DIGITS, 6, number of BCD output digits (legal 1..10).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request conversion; sampled only while busy=0.
- value  in  IN_WIDTH  unsigned binary value; captured on the accepting edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; results valid and updated in that same cycle.
- bcd  out  4*NUM_DIGITS  packed BCD result; digit 0 (ones) in bits [3:0].
- blank  out  NUM_DIGITS  per-digit leading-zero mask; bit i=1 means digit i is a leading zero and should be blanked.
- overflow  out  1  high when the last converted value was >= 10^NUM_DIGITS.

Behaviour:
- Reset is synchronous and active-high on clock; it is the only reset and has priority over everything.
- Reset values: busy=0, done=0, bcd=0, overflow=0, blank = all ones except bit 0 (a reset display shows a single "0"). FSM=IDLE, iteration counter=0.
- States: IDLE, SHIFT.
- IDLE:
  - If start=1 at edge k: capture value into the shift register, clear the internal BCD accumulator, set counter=0, busy=1, go to SHIFT.
  - If start=0: outputs hold.
- SHIFT:
  - Each edge performs one double-dabble iteration: every internal digit >=5 gets +3, then the {accumulator, shift register} is shifted left 1 and the counter increments.
  - The internal accumulator holds ID = ceil(IN_WIDTH*log10(2)) digits (10 for IN_WIDTH=32), so that overflow can be detected.
- Completion:
  - The iteration with counter=IN_WIDTH-1 occurs at edge k+IN_WIDTH.
  - At that same edge, the final digits are registered into bcd/blank/overflow, done=1 and busy=0, and the FSM returns to IDLE.
  - Latency is exactly IN_WIDTH cycles from the accepting edge to done high.
- done is high for exactly one cycle.
- bcd, blank and overflow change only at a completion edge (or at reset). They hold otherwise, including while busy.
- Overflow: if any internal digit at index >= NUM_DIGITS is nonzero, overflow=1 and bcd saturates to all digits 9 with blank=0. Otherwise overflow=0 and bcd = the low NUM_DIGITS internal digits.
- blank: bit i=1 iff digits i..NUM_DIGITS-1 are all zero and i>0. Digit 0 is never blanked.
- start while busy=1 is ignored; there is no queueing. The value input may change freely while busy.
- Back-to-back: start=1 during the done cycle is accepted, because busy=0 in that cycle. The next done follows IN_WIDTH cycles later.
- Reset mid-conversion aborts it: no done pulse, and all outputs return to reset values.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan (IN_WIDTH=32, NUM_DIGITS=6 unless noted):
1. Reset, then start with value=0 → done exactly 32 cycles after the accept edge; bcd=24'h000000, blank=6'b111110, overflow=0.
2. value=123456 → bcd=24'h123456, blank=6'b000000, overflow=0. busy is high for 32 cycles, and done is a single-cycle pulse.
3. value=907 → bcd=24'h000907, blank=6'b111000.
4. value=999999 → bcd=24'h999999, overflow=0. value=1000000 → bcd=24'h999999, overflow=1, blank=0. value=32'hFFFFFFFF → bcd=24'h999999, overflow=1.
5. Handshake:
   - start value=42, then pulse start with value=77 at cycle 10 while busy → ignored; result is 24'h000042.
   - Assert start with value=77 in the done cycle → accepted; bcd=24'h000077 32 cycles later.
   - Outputs hold the previous result while busy.
6. Start value=555, assert reset at cycle 15 → no done pulse; outputs return to reset values on the next edge. A new start value=8 then yields bcd=24'h000008, blank=6'b111110. Also repeat test 2 with IN_WIDTH=16, NUM_DIGITS=5, value=65535 → bcd=20'h65535, done after 16 cycles.
